// File: rtl/scpu_pkg.sv
// Shared types and constants for the single-cycle CPU fetch path.
package scpu_pkg;
    localparam int PC_W       = 10;
    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;
endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: jr > jump > branch > sequential, all modulo 2^PC_W.
module pc_next_calc
    import scpu_pkg::*;
(
    input  logic [PC_W-1:0] i_pc,
    input  logic            i_branch_taken,
    input  logic [15:0]     i_branch_offset,
    input  logic            i_jump,
    input  logic [25:0]     i_jump_index,
    input  logic            i_jr,
    input  logic [31:0]     i_jr_target,
    output logic [PC_W-1:0] o_pc_plus4,
    output logic [PC_W-1:0] o_next_pc,
    output logic            o_misalign
);
    logic [PC_W-1:0] w_br_disp;
    logic [PC_W-1:0] w_br_target;
    logic [PC_W-1:0] w_jmp_target;
    logic [PC_W-1:0] w_jr_target;
    logic            w_unused;

    assign o_pc_plus4 = i_pc + PC_W'(WORD_BYTES);

    // Word offset shifted left by two and truncated: upper offset bits cannot affect a PC_W result.
    assign w_br_disp    = {i_branch_offset[PC_W-3:0], 2'b00};
    assign w_br_target  = o_pc_plus4 + w_br_disp;
    assign w_jmp_target = {i_jump_index[PC_W-3:0], 2'b00};
    assign w_jr_target  = {i_jr_target[PC_W-1:2], 2'b00};

    assign w_unused = ^{i_branch_offset[15:PC_W-2], i_jump_index[25:PC_W-2], i_jr_target[31:PC_W]};

    always_comb begin
        o_next_pc = o_pc_plus4;
        if (i_jr)
            o_next_pc = w_jr_target;
        else if (i_jump)
            o_next_pc = w_jmp_target;
        else if (i_branch_taken)
            o_next_pc = w_br_target;
    end

    assign o_misalign = i_jr && (i_jr_target[1:0] != 2'b00);
endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, BOOT/RUN/HALT fetch sequencer and saturating fetch counter.
// state | meaning
// BOOT  | first cycle after reset release, pc held, no fetch
// RUN   | fetching; fetch_valid = ~stall
// HALT  | parked until resume, no fetch
module pc_fetch_unit
    import scpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             halt,
    input  logic             resume,
    input  logic             branch_taken,
    input  logic [15:0]      branch_offset,
    input  logic             jump,
    input  logic [25:0]      jump_index,
    input  logic             jr,
    input  logic [31:0]      jr_target,
    output logic [PC_W-1:0]  pc,
    output logic [PC_W-1:0]  pc_plus4,
    output logic             fetch_valid,
    output logic             misalign,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_count
);
    state_t           r_state;
    state_t           w_state_nxt;
    logic [PC_W-1:0]  r_pc;
    logic             r_misalign;
    logic [CNT_W-1:0] r_fetch_count;
    logic [PC_W-1:0]  w_next_pc;
    logic             w_mis_cond;
    logic             w_fetch_valid;
    logic             w_halted;
    logic             w_pc_load;

    pc_next_calc u_next (
        .i_pc            (r_pc),
        .i_branch_taken  (branch_taken),
        .i_branch_offset (branch_offset),
        .i_jump          (jump),
        .i_jump_index    (jump_index),
        .i_jr            (jr),
        .i_jr_target     (jr_target),
        .o_pc_plus4      (pc_plus4),
        .o_next_pc       (w_next_pc),
        .o_misalign      (w_mis_cond)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_BOOT;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_BOOT: w_state_nxt = ST_RUN;
            ST_RUN:  if (!stall && halt) w_state_nxt = ST_HALT;
            ST_HALT: if (resume) w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_BOOT;
        endcase
    end

    always_comb begin
        w_fetch_valid = 1'b0;
        w_halted      = 1'b0;
        w_pc_load     = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_fetch_valid = !stall;
                w_pc_load     = !stall && !halt;
            end
            ST_HALT: w_halted = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_misalign    <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            if (w_pc_load)
                r_pc <= w_next_pc;
            r_misalign <= w_pc_load && w_mis_cond;
            if (w_fetch_valid && (r_fetch_count != {CNT_W{1'b1}}))
                r_fetch_count <= r_fetch_count + 1'b1;
        end
    end

    assign pc          = r_pc;
    assign fetch_valid = w_fetch_valid;
    assign misalign    = r_misalign;
    assign halted      = w_halted;
    assign fetch_count = r_fetch_count;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Vector table with a post-edge scoreboard, plus hand sequences for reset and BOOT/halt corners.
module tb_pc_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, halt, resume, branch_taken, jump, jr;
    logic [15:0] branch_offset;
    logic [25:0] jump_index;
    logic [31:0] jr_target;
    logic [9:0]  pc, pc_plus4, s_pc, s_pc_plus4;
    logic        fetch_valid, misalign, halted, s_fv, s_mis, s_halted;
    logic [31:0] fetch_count;
    logic [2:0]  s_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pc_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .halt(halt), .resume(resume),
        .branch_taken(branch_taken), .branch_offset(branch_offset), .jump(jump),
        .jump_index(jump_index), .jr(jr), .jr_target(jr_target), .pc(pc),
        .pc_plus4(pc_plus4), .fetch_valid(fetch_valid), .misalign(misalign),
        .halted(halted), .fetch_count(fetch_count)
    );

    // Narrow counter instance to reach saturation quickly.
    pc_fetch_unit #(.CNT_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .stall(stall), .halt(halt), .resume(resume),
        .branch_taken(branch_taken), .branch_offset(branch_offset), .jump(jump),
        .jump_index(jump_index), .jr(jr), .jr_target(jr_target), .pc(s_pc),
        .pc_plus4(s_pc_plus4), .fetch_valid(s_fv), .misalign(s_mis),
        .halted(s_halted), .fetch_count(s_count)
    );

    typedef struct {
        logic        st, hl, rs, br;
        logic [15:0] off;
        logic        jp;
        logic [25:0] idx;
        logic        jr;
        logic [31:0] tgt;
        logic [9:0]  e_pc;
        logic        e_fv, e_halted;
        logic [9:0]  e_npc;
        logic        e_mis;
        int          e_cnt;
    } vec_t;

    typedef struct {
        int          id;
        logic [9:0]  pc;
        logic        mis;
        int          cnt;
    } post_t;

    vec_t  vecs[$];
    post_t sb[$];

    function automatic vec_t mk(input logic st, hl, rs, br, input logic [15:0] off,
                                input logic jp, input logic [25:0] idx,
                                input logic jrq, input logic [31:0] tgt,
                                input logic [9:0] e_pc, input logic e_fv, e_halted,
                                input logic [9:0] e_npc, input logic e_mis, input int e_cnt);
        vec_t v;
        v.st = st; v.hl = hl; v.rs = rs; v.br = br; v.off = off;
        v.jp = jp; v.idx = idx; v.jr = jrq; v.tgt = tgt;
        v.e_pc = e_pc; v.e_fv = e_fv; v.e_halted = e_halted;
        v.e_npc = e_npc; v.e_mis = e_mis; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        stall = 0; halt = 0; resume = 0; branch_taken = 0; jump = 0; jr = 0;
        branch_offset = '0; jump_index = '0; jr_target = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        post_t p;
        logic [9:0] e_p4;

        //     st hl rs br off       jp idx      jr tgt           pc     fv hd  npc    mis cnt
        vecs.push_back(mk(0,0,0,0,16'h0000,0,26'h00,0,32'h0,      10'h000,0,0, 10'h000,0, 0));
        vecs.push_back(mk(0,0,0,0,16'h0000,0,26'h00,0,32'h0,      10'h000,1,0, 10'h004,0, 1));
        vecs.push_back(mk(0,0,0,0,16'h0000,0,26'h00,0,32'h0,      10'h004,1,0, 10'h008,0, 2));
        vecs.push_back(mk(0,0,0,0,16'h0000,1,26'h04,0,32'h0,      10'h008,1,0, 10'h010,0, 3));
        vecs.push_back(mk(0,0,0,1,16'hFFFE,0,26'h00,0,32'h0,      10'h010,1,0, 10'h00C,0, 4));
        vecs.push_back(mk(0,0,0,0,16'h0000,1,26'h04,0,32'h0,      10'h00C,1,0, 10'h010,0, 5));
        vecs.push_back(mk(0,0,0,1,16'h0003,0,26'h00,0,32'h0,      10'h010,1,0, 10'h020,0, 6));
        vecs.push_back(mk(0,0,0,0,16'h0000,1,26'h10,0,32'h0,      10'h020,1,0, 10'h040,0, 7));
        vecs.push_back(mk(0,0,0,1,16'h0001,1,26'h50,1,32'h123,    10'h040,1,0, 10'h120,1, 8));
        vecs.push_back(mk(0,0,0,0,16'h0000,0,26'h00,0,32'h0,      10'h120,1,0, 10'h124,0, 9));
        vecs.push_back(mk(0,0,0,0,16'h0000,1,26'hFF,0,32'h0,      10'h124,1,0, 10'h3FC,0,10));
        vecs.push_back(mk(0,0,0,0,16'h0000,0,26'h00,0,32'h0,      10'h3FC,1,0, 10'h000,0,11));
        vecs.push_back(mk(0,0,0,0,16'h0000,1,26'h14,0,32'h0,      10'h000,1,0, 10'h050,0,12));
        vecs.push_back(mk(1,0,0,1,16'h0005,0,26'h00,0,32'h0,      10'h050,0,0, 10'h050,0,12));
        vecs.push_back(mk(1,1,0,0,16'h0000,1,26'h00,0,32'h0,      10'h050,0,0, 10'h050,0,12));
        vecs.push_back(mk(1,0,0,0,16'h0000,0,26'h00,0,32'h0,      10'h050,0,0, 10'h050,0,12));
        vecs.push_back(mk(0,1,0,0,16'h0000,1,26'h00,0,32'h0,      10'h050,1,0, 10'h050,0,13));
        vecs.push_back(mk(0,1,0,1,16'h0007,0,26'h00,0,32'h0,      10'h050,0,1, 10'h050,0,13));
        vecs.push_back(mk(1,0,0,0,16'h0007,0,26'h00,0,32'h0,      10'h050,0,1, 10'h050,0,13));
        vecs.push_back(mk(0,0,1,0,16'h0000,0,26'h00,1,32'h200,    10'h050,0,1, 10'h050,0,13));
        vecs.push_back(mk(0,0,1,0,16'h0000,0,26'h00,0,32'h0,      10'h050,1,0, 10'h054,0,14));
        vecs.push_back(mk(0,0,0,0,16'h0000,0,26'h00,1,32'hFFFFF402,10'h054,1,0,10'h000,1,15));
        vecs.push_back(mk(0,0,0,0,16'h0000,1,26'h68,0,32'h0,      10'h000,1,0, 10'h1A0,0,16));

        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("rst pc", 32'(pc), 32'h000);
        chk("rst pc_plus4", 32'(pc_plus4), 32'h004);
        chk("rst fetch_valid", 32'(fetch_valid), 0);
        chk("rst halted", 32'(halted), 0);
        chk("rst misalign", 32'(misalign), 0);
        chk("rst fetch_count", fetch_count, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            stall = vecs[i].st; halt = vecs[i].hl; resume = vecs[i].rs;
            branch_taken = vecs[i].br; branch_offset = vecs[i].off;
            jump = vecs[i].jp; jump_index = vecs[i].idx;
            jr = vecs[i].jr; jr_target = vecs[i].tgt;
            #1;
            e_p4 = vecs[i].e_pc + 10'd4;
            chk($sformatf("v%0d pc", i), 32'(pc), 32'(vecs[i].e_pc));
            chk($sformatf("v%0d pc_plus4", i), 32'(pc_plus4), 32'(e_p4));
            chk($sformatf("v%0d fetch_valid", i), 32'(fetch_valid), 32'(vecs[i].e_fv));
            chk($sformatf("v%0d halted", i), 32'(halted), 32'(vecs[i].e_halted));
            p.id = i; p.pc = vecs[i].e_npc; p.mis = vecs[i].e_mis; p.cnt = vecs[i].e_cnt;
            sb.push_back(p);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL scoreboard: empty queue at vector %0d", i);
            end else begin
                p = sb.pop_front();
                chk($sformatf("v%0d next pc", p.id), 32'(pc), 32'(p.pc));
                chk($sformatf("v%0d misalign", p.id), 32'(misalign), 32'(p.mis));
                chk($sformatf("v%0d fetch_count", p.id), fetch_count, 32'(p.cnt));
            end
        end
        chk("sat fetch_count", 32'(s_count), 32'd7);

        // Async reset mid-cycle at pc=0x1A0, then halt held through BOOT.
        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        chk("async pc", 32'(pc), 32'h000);
        chk("async fetch_count", fetch_count, 0);
        chk("async misalign", 32'(misalign), 0);
        chk("async sat count", 32'(s_count), 0);
        @(negedge clk);
        halt = 1'b1;
        #1 rst_n = 1'b1;
        #1;
        chk("boot fetch_valid", 32'(fetch_valid), 0);
        chk("boot halted", 32'(halted), 0);
        @(posedge clk);
        #1;
        chk("boot->run halted", 32'(halted), 0);
        chk("boot->run fetch_valid", 32'(fetch_valid), 1);
        chk("boot->run pc", 32'(pc), 32'h000);
        @(posedge clk);
        #1;
        chk("run->halt halted", 32'(halted), 1);
        chk("run->halt pc", 32'(pc), 32'h000);
        chk("run->halt fetch_count", fetch_count, 1);

        if (sb.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Program-counter and fetch-sequencing stage directly upstream of the byte-addressed instruction memory in the single-cycle CPU. Holds the 10-bit byte PC and drives the memory's PC input. Computes the next PC from sequential, branch, jump and jump-register requests. Provides stall/halt control and a fetch counter for debug.

Parameters:
PC_W, 10, byte-address width of PC; wraps modulo 2^PC_W
RESET_PC, 0, PC value loaded on reset; must be a multiple of 4
CNT_W, 32, width of fetch_count

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  hold PC this cycle; redirects not sampled
halt  in  1  request entry to HALT
resume  in  1  leave HALT
branch_taken  in  1  take conditional branch
branch_offset  in  16  signed word offset relative to PC+4
jump  in  1  absolute jump
jump_index  in  26  J-format index; bits [PC_W-3:0] used
jr  in  1  jump to register
jr_target  in  32  register byte address; bits [PC_W-1:0] used
pc  out  PC_W  current fetch address to instruction memory
pc_plus4  out  PC_W  pc+4, combinational, wraps
fetch_valid  out  1  instruction at pc is being consumed this cycle
misalign  out  1  one-cycle pulse: last jr target had nonzero [1:0]
halted  out  1  high while in HALT
fetch_count  out  CNT_W  number of cycles with fetch_valid=1, saturating

Behaviour:
- One clock domain. Reset is asynchronous and active-low: rst_n low immediately forces pc=RESET_PC, state=BOOT, misalign=0, fetch_count=0. This gives fetch_valid=0, halted=0 and pc_plus4=RESET_PC+4.
- FSM states:
  - BOOT: one cycle after reset release; pc held; fetch_valid=0; next state RUN unconditionally, even if halt is asserted.
  - RUN: fetch_valid = ~stall.
  - HALT: fetch_valid=0; halted=1.
- RUN transitions, by priority:
  - stall=1: pc held, FSM stays in RUN, halt ignored this cycle.
  - else halt=1: go to HALT; pc held; redirects ignored.
  - else pc <= next_pc.
- HALT transitions: resume=1 moves to RUN on the next edge; pc unchanged. halt, stall and redirects are ignored in HALT.
- next_pc priority: jr > jump > branch_taken > sequential.
  - jr: {jr_target[PC_W-1:2],2'b00}.
  - jump: {jump_index[PC_W-3:0],2'b00}.
  - branch: pc_plus4 + (sign_extend(branch_offset) << 2), truncated to PC_W.
  - sequential: pc_plus4.
- All adds wrap modulo 2^PC_W with no overflow flag. pc is always word-aligned.
- misalign: registered. It is 1 in the cycle after an edge where a jr redirect was applied with jr_target[1:0]!=0; otherwise 0. jr_target bits above PC_W are silently dropped.
- Redirect latency: a request sampled at edge N appears on pc after edge N. The requester must hold it through stall cycles.
- fetch_count increments at each edge where fetch_valid=1 and holds at all-ones (saturates).
- Reset asserted mid-operation wins over every other input in the same cycle.

Decomposition:
- Shared package scpu_pkg holds: PC_W; the FSM state typedef (BOOT, RUN, HALT); and the constant WORD_BYTES=4.
- One combinational sub-module, pc_next_calc: inputs pc and the redirect fields, outputs next_pc and the misalign condition.
- FSM, PC register and counter live in pc_fetch_unit.

Test Plan:
- Reset, then release with idle inputs:
  - BOOT cycle: pc=0x000, fetch_valid=0.
  - Next cycles: pc=0x000, 0x004, 0x008; fetch_count=1,2,3.
- Wrap-around: run from pc=0x3FC sequentially -> pc=0x000 next cycle; pc_plus4 at 0x3FC reads 0x000.
- Branch arithmetic, with branch_taken:
  - At pc=0x010, branch_offset=0xFFFE (-2) -> pc=0x00C.
  - At pc=0x010, branch_offset=0x0003 -> pc=0x020.
- Priority: jr=1 with jr_target=0x0000_0123, plus jump and branch_taken also asserted, at pc=0x040:
  - pc=0x120.
  - misalign=1 for exactly one cycle.
- Stall and halt:
  - stall=1 for 3 cycles at pc=0x050: pc stays 0x050, fetch_valid=0, fetch_count unchanged.
  - Then halt=1: halted=1 next cycle; pc stays 0x050 while branch_taken is toggled.
  - resume=1: RUN resumes; pc advances to 0x054.
- Async reset: drop rst_n mid-cycle while pc=0x1A0 -> pc=0x000 and fetch_count=0 immediately, without waiting for a clock edge.
